dca_matrix_step_gen: RTL and testbench



---
 rtl/dca_matrix_step_gen_pkg.sv | 53 +++++
 rtl/dca_edge_mask_gen.sv | 21 ++
 rtl/dca_matrix_step_gen.sv | 181 ++++++++++++++++++
 tb/tb_dca_matrix_step_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_step_gen_pkg.sv
// Shared definitions for the DCA matrix step generator and the MAC step
// controller: opcode bit positions, step-instruction packing, FSM states.
package dca_matrix_step_gen_pkg;

    localparam int MATRIX_SIZE  = 8;
    localparam int BW_BLOCK_CNT = 8;
    localparam int BW_REM       = $clog2(MATRIX_SIZE);

    localparam int NO_CAL   = 0;
    localparam int LSU0_REQ = 1;
    localparam int LSU1_REQ = 2;
    localparam int LSU2_REQ = 3;
    localparam int LOAD_ACC = 4;
    localparam int BW_OPCODE = 5;

    localparam int BW_STEP_INST = 2 * MATRIX_SIZE + 1 + BW_OPCODE;

    typedef logic [BW_OPCODE-1:0]    opcode_t;
    typedef logic [BW_BLOCK_CNT-1:0] blk_cnt_t;
    typedef logic [BW_REM-1:0]       rem_t;
    typedef logic [MATRIX_SIZE-1:0]  mask_t;

    typedef struct packed {
        mask_t   row_mask;
        mask_t   col_mask;
        logic    last;
        opcode_t opcode;
    } step_inst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_MAC
    } state_e;

    function automatic opcode_t preload_opcode();
        opcode_t op;
        op           = '0;
        op[NO_CAL]   = 1'b1;
        op[LOAD_ACC] = 1'b1;
        return op;
    endfunction

    function automatic opcode_t mac_opcode(input logic final_k);
        opcode_t op;
        op           = '0;
        op[LSU0_REQ] = 1'b1;
        op[LSU1_REQ] = 1'b1;
        op[LSU2_REQ] = final_k;
        return op;
    endfunction

endpackage

// File: rtl/dca_edge_mask_gen.sv
// Per-axis lane mask: all ones, or the low `rem` lanes on the last
// (partial) block of an axis.
module dca_edge_mask_gen
    import dca_matrix_step_gen_pkg::*;
(
    input  logic  is_last_blk_i,
    input  rem_t  rem_i,
    output mask_t mask_o
);

    // Trim the mask only on a partial final block.
    always_comb begin
        mask_o = '1;
        if (is_last_blk_i && (rem_i != '0)) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                mask_o[i] = (i < int'(rem_i));
            end
        end
    end

endmodule

// File: rtl/dca_matrix_step_gen.sv
// Expands one tiled GEMM command into a registered stream of blocked step
// instructions (r outer, c middle, k inner) with a valid/pop handshake.
module dca_matrix_step_gen
    import dca_matrix_step_gen_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [BW_BLOCK_CNT-1:0] cmd_num_row_blk,
    input  logic [BW_BLOCK_CNT-1:0] cmd_num_col_blk,
    input  logic [BW_BLOCK_CNT-1:0] cmd_num_k_blk,
    input  logic [BW_REM-1:0]       cmd_row_rem,
    input  logic [BW_REM-1:0]       cmd_col_rem,
    input  logic                    cmd_load_acc,
    output logic                    step_valid,
    output logic [BW_STEP_INST-1:0] step_inst,
    input  logic                    step_pop,
    output logic                    busy,
    output logic                    done
);

    localparam blk_cnt_t ONE = blk_cnt_t'(1);

    state_e     state_q, state_d;
    blk_cnt_t   r_q, r_d, c_q, c_d, k_q, k_d;
    blk_cnt_t   nr_q, nr_d, nc_q, nc_d, nk_q, nk_d;
    rem_t       row_rem_q, row_rem_d, col_rem_q, col_rem_d;
    logic       load_acc_q, load_acc_d;
    logic       done_q, done_d;
    step_inst_t inst_q, inst_d;

    logic  row_last_d, col_last_d, k_last_d;
    mask_t row_mask_d, col_mask_d;

    logic  accept;
    logic  zero_dim;
    logic  pop;
    logic  k_end, c_end, r_end;

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign zero_dim = (cmd_num_row_blk == '0) || (cmd_num_col_blk == '0)
                   || (cmd_num_k_blk == '0);
    assign pop      = step_pop && (state_q != ST_IDLE);
    assign k_end    = (k_q == nk_q - ONE);
    assign c_end    = (c_q == nc_q - ONE);
    assign r_end    = (r_q == nr_q - ONE);

    // Next-state logic: command latch, tile iteration and completion.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        nr_d       = nr_q;
        nc_d       = nc_q;
        nk_d       = nk_q;
        row_rem_d  = row_rem_q;
        col_rem_d  = col_rem_q;
        load_acc_d = load_acc_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    nr_d       = cmd_num_row_blk;
                    nc_d       = cmd_num_col_blk;
                    nk_d       = cmd_num_k_blk;
                    row_rem_d  = cmd_row_rem;
                    col_rem_d  = cmd_col_rem;
                    load_acc_d = cmd_load_acc;
                    r_d        = '0;
                    c_d        = '0;
                    k_d        = '0;
                    if (zero_dim) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd_load_acc ? ST_PRELOAD : ST_MAC;
                    end
                end
            end
            ST_PRELOAD: begin
                if (pop) begin
                    state_d = ST_MAC;
                    k_d     = '0;
                end
            end
            ST_MAC: begin
                if (pop) begin
                    if (!k_end) begin
                        k_d = k_q + ONE;
                    end else begin
                        k_d = '0;
                        if (r_end && c_end) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            if (c_end) begin
                                c_d = '0;
                                r_d = r_q + ONE;
                            end else begin
                                c_d = c_q + ONE;
                            end
                            state_d = load_acc_q ? ST_PRELOAD : ST_MAC;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign row_last_d = (r_d == nr_d - ONE);
    assign col_last_d = (c_d == nc_d - ONE);
    assign k_last_d   = (k_d == nk_d - ONE);

    dca_edge_mask_gen u_row_mask (
        .is_last_blk_i (row_last_d),
        .rem_i         (row_rem_d),
        .mask_o        (row_mask_d)
    );

    dca_edge_mask_gen u_col_mask (
        .is_last_blk_i (col_last_d),
        .rem_i         (col_rem_d),
        .mask_o        (col_mask_d)
    );

    // Build the step presented in the next cycle from the next counters.
    always_comb begin
        inst_d = '0;
        if (state_d != ST_IDLE) begin
            inst_d.row_mask = row_mask_d;
            inst_d.col_mask = col_mask_d;
            if (state_d == ST_PRELOAD) begin
                inst_d.opcode = preload_opcode();
            end else begin
                inst_d.opcode = mac_opcode(k_last_d);
                inst_d.last   = row_last_d && col_last_d && k_last_d;
            end
        end
    end

    // State, counters, latched command and registered step output.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            nr_q       <= '0;
            nc_q       <= '0;
            nk_q       <= '0;
            row_rem_q  <= '0;
            col_rem_q  <= '0;
            load_acc_q <= 1'b0;
            done_q     <= 1'b0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            nr_q       <= nr_d;
            nc_q       <= nc_d;
            nk_q       <= nk_d;
            row_rem_q  <= row_rem_d;
            col_rem_q  <= col_rem_d;
            load_acc_q <= load_acc_d;
            done_q     <= done_d;
            inst_q     <= inst_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign step_valid = (state_q != ST_IDLE);
    assign step_inst  = inst_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dca_matrix_step_gen.sv
// Self-checking bench: a queue of expected steps built with nested loops is
// compared against the DUT every cycle, plus literal checks of key runs.
module tb_dca_matrix_step_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_num_row_blk;
    logic [7:0]  cmd_num_col_blk;
    logic [7:0]  cmd_num_k_blk;
    logic [2:0]  cmd_row_rem;
    logic [2:0]  cmd_col_rem;
    logic        cmd_load_acc;
    logic        step_valid;
    logic [21:0] step_inst;
    logic        step_pop;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [21:0] exp_q[$];
    logic        exp_done = 1'b0;
    bit          started  = 1'b0;
    logic [21:0] log_q[$];

    always #5 clk = ~clk;

    dca_matrix_step_gen dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_num_row_blk (cmd_num_row_blk),
        .cmd_num_col_blk (cmd_num_col_blk),
        .cmd_num_k_blk   (cmd_num_k_blk),
        .cmd_row_rem     (cmd_row_rem),
        .cmd_col_rem     (cmd_col_rem),
        .cmd_load_acc    (cmd_load_acc),
        .step_valid      (step_valid),
        .step_inst       (step_inst),
        .step_pop        (step_pop),
        .busy            (busy),
        .done            (done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] edge_mask(input int idx, input int n,
                                             input int rem);
        if (idx == n - 1 && rem != 0) return 8'((1 << rem) - 1);
        return 8'hFF;
    endfunction

    // Reference model: whole command expanded into a queue on accept.
    always @(posedge clk) begin
        logic nd;
        int R, C, K, rr, cr;
        logic [7:0] rm, cm;
        started = 1'b1;
        nd = 1'b0;
        if (rst || clear) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (step_pop) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) nd = 1'b1;
            end
        end else if (cmd_valid) begin
            R  = int'(cmd_num_row_blk);
            C  = int'(cmd_num_col_blk);
            K  = int'(cmd_num_k_blk);
            rr = int'(cmd_row_rem);
            cr = int'(cmd_col_rem);
            if (R == 0 || C == 0 || K == 0) nd = 1'b1;
            else begin
                for (int r = 0; r < R; r++) begin
                    for (int c = 0; c < C; c++) begin
                        rm = edge_mask(r, R, rr);
                        cm = edge_mask(c, C, cr);
                        if (cmd_load_acc) exp_q.push_back({rm, cm, 1'b0, 5'b10001});
                        for (int k = 0; k < K; k++) begin
                            exp_q.push_back({rm, cm,
                                1'(r == R - 1 && c == C - 1 && k == K - 1),
                                (k == K - 1) ? 5'b01110 : 5'b00110});
                        end
                    end
                end
            end
        end
        exp_done = nd;
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (started) begin
            chk("step_valid", 32'(step_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() == 0));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_q.size() != 0) chk("step_inst", 32'(step_inst), 32'(exp_q[0]));
            if (step_valid === 1'b1 && step_pop === 1'b1) log_q.push_back(step_inst);
        end
    end

    // mode: 0 pop always, 1 random pop, 2 stall 5 cycles at step stall_at
    task automatic run_cmd(input int R, input int C, input int K,
                           input int rr, input int cr, input bit la,
                           input int mode, input int stall_at,
                           input int clear_at);
        int pops = 0;
        int stall = 0;
        int cyc = 0;
        bit cleared = 0;
        @(negedge clk);
        log_q.delete();
        cmd_num_row_blk = 8'(R);
        cmd_num_col_blk = 8'(C);
        cmd_num_k_blk   = 8'(K);
        cmd_row_rem     = 3'(rr);
        cmd_col_rem     = 3'(cr);
        cmd_load_acc    = la;
        cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            cyc++;
            clear = 1'b0;
            if (clear_at >= 0 && pops == clear_at && !cleared) begin
                clear    = 1'b1;
                cleared  = 1;
                step_pop = 1'b0;
            end else if (mode == 2 && pops == stall_at && stall < 5) begin
                step_pop = 1'b0;
                stall++;
            end else if (mode == 1) begin
                step_pop = ($urandom_range(0, 2) != 0);
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_num_k_blk = 8'($urandom_range(0, 3));
            end else begin
                step_pop = 1'b1;
            end
            if (step_pop) pops++;
            @(negedge clk);
        end
        if (cyc >= 2000) chk("cycle_budget", 32'(cyc), 32'(0));
        clear     = 1'b0;
        step_pop  = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] ops[4];
        logic [15:0] masks[4];
        rst = 1'b1; clear = 1'b0; cmd_valid = 1'b0; step_pop = 1'b0;
        cmd_num_row_blk = '0; cmd_num_col_blk = '0; cmd_num_k_blk = '0;
        cmd_row_rem = '0; cmd_col_rem = '0; cmd_load_acc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step_valid", 32'(step_valid), 32'(0));
        chk("rst_step_inst", 32'(step_inst), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        rst = 1'b0;

        run_cmd(1, 1, 1, 0, 0, 0, 0, 0, -1);
        chk("t1_count", 32'(log_q.size()), 32'(1));
        if (log_q.size() == 1)
            chk("t1_inst", 32'(log_q[0]), 32'({8'hFF, 8'hFF, 1'b1, 5'b01110}));

        ops[0] = 5'b10001; ops[1] = 5'b00110;
        ops[2] = 5'b00110; ops[3] = 5'b01110;
        run_cmd(2, 1, 3, 0, 0, 1, 0, 0, -1);
        chk("t2_count", 32'(log_q.size()), 32'(8));
        for (int i = 0; i < log_q.size() && i < 8; i++) begin
            chk("t2_opcode", 32'(log_q[i][4:0]), 32'(ops[i % 4]));
            chk("t2_last", 32'(log_q[i][5]), 32'(i == 7));
        end

        masks[0] = 16'hFFFF; masks[1] = 16'hFF1F;
        masks[2] = 16'h07FF; masks[3] = 16'h071F;
        run_cmd(2, 2, 1, 3, 5, 0, 0, 0, -1);
        chk("t3_count", 32'(log_q.size()), 32'(4));
        for (int i = 0; i < log_q.size() && i < 4; i++)
            chk("t3_masks", 32'(log_q[i][21:6]), 32'(masks[i]));

        run_cmd(2, 1, 3, 0, 0, 1, 2, 1, -1);
        chk("t4_count", 32'(log_q.size()), 32'(8));

        run_cmd(1, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("t5_count", 32'(log_q.size()), 32'(0));

        run_cmd(2, 1, 3, 0, 0, 1, 0, 0, 2);
        chk("t6_count", 32'(log_q.size()), 32'(2));
        run_cmd(1, 1, 1, 0, 0, 0, 0, 0, -1);
        chk("t6_new_count", 32'(log_q.size()), 32'(1));

        for (int n = 0; n < 40; n++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 7),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    1, 0, ($urandom_range(0, 7) == 0) ? 3 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
